fetch_unit: RTL and testbench

Instruction fetch stage: produces the 32-bit instruction words that the decode stage consumes using the `pipes` opcode definitions. It issues one-at-a-time requests on the instruction bus and buffers up to two fetched {pc, instr} pairs in a FIFO. It presents them to decode with a valid/ready handshake and handles branch/jump redirects from execute, including discarding in-flight responses.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-at-a-time instruction bus requests, 2-entry {pc, instr} FIFO to decode,
// redirect handling with in-flight response discard. Define FETCH_STATS_EN to add fetch/drop counters.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_dropped,
`endif
    output logic            out_predec_br
);

    // Major opcodes (instr[31:26]) from the pipes ISA definitions.
    localparam logic [5:0] F6_J   = 6'h02;
    localparam logic [5:0] F6_BEQ = 6'h04;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [1:0]      count;
    logic            rd_ptr;

    logic [XLEN-1:0] fifo_pc    [2];
    logic [31:0]     fifo_instr [2];

    logic            push;
    logic            pop;
    logic            wr_ptr;
    logic [1:0]      count_next;
    logic [XLEN-1:0] target;

    // Redirect cycles mask out_valid so decode never pops an entry that is being flushed.
    assign out_valid     = (count != 2'd0) && !redirect_valid;
    assign pop           = out_valid && out_ready;
    assign push          = (state == S_WAIT) && iresp_ok && !redirect_valid;
    assign count_next    = count + 2'(push) - 2'(pop);
    assign wr_ptr        = rd_ptr ^ count[0];
    assign target        = {redirect_pc[XLEN-1:2], 2'b00};

    assign ireq_valid    = (state == S_WAIT) || (state == S_FLUSH);
    assign ireq_addr     = req_pc;
    assign out_pc        = fifo_pc[rd_ptr];
    assign out_instr     = fifo_instr[rd_ptr];
    assign out_predec_br = (out_instr[31:26] == F6_J) || (out_instr[31:26] == F6_BEQ);

    // NOTE: FIFO storage has no reset; count qualifies every entry, so clearing data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= iresp_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every branch sees start-of-cycle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
`ifdef FETCH_STATS_EN
            stat_fetched <= '0;
            stat_dropped <= '0;
`endif
        end else begin
            count <= count_next;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
`ifdef FETCH_STATS_EN
            if (push) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (state != S_IDLE && iresp_ok && (redirect_valid || state == S_FLUSH)) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
`endif
            unique case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        count <= 2'd0;
                    end else if (count_next < 2'd2) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        count <= 2'd0;
                        state <= iresp_ok ? S_IDLE : S_FLUSH;
                    end else if (iresp_ok) begin
                        pc <= req_pc + XLEN'(4);
                        // Keep requesting back-to-back only while a FIFO slot is guaranteed.
                        if (count_next < 2'd2) begin
                            req_pc <= req_pc + XLEN'(4);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        count <= 2'd0;
                    end
                    if (iresp_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a request/queue reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_predec_br;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_dropped;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef FETCH_STATS_EN
        .stat_fetched   (stat_fetched),
        .stat_dropped   (stat_dropped),
`endif
        .out_predec_br  (out_predec_br)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding request (with a discard mark) and a queue of fetched pairs.
    bit          m_known   = 0;
    bit          m_active  = 0;
    bit          m_discard = 0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_pc      = '0;
    logic [31:0] q_pc  [$];
    logic [31:0] q_ins [$];
    int unsigned m_fetched = 0;
    int unsigned m_dropped = 0;
    bit          data_is_addr = 0;

    task automatic q_flush();
        q_pc.delete();
        q_ins.delete();
    endtask

    task automatic q_pop();
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
    endtask

    always @(negedge clk) begin
        bit          ov;
        bit          pop;
        logic [31:0] head;
        logic [5:0]  opc;
        logic [31:0] tgt;
        ov  = (q_pc.size() != 0) && !redirect_valid;
        pop = ov && out_ready;
        if (m_known) begin
            check("ireq_valid", 32'(ireq_valid), 32'(m_active));
            if (m_active) check("ireq_addr", ireq_addr, m_addr);
            check("out_valid", 32'(out_valid), 32'(ov));
            if (ov) begin
                head = q_ins[0];
                opc  = head[31:26];
                check("out_pc", out_pc, q_pc[0]);
                check("out_instr", out_instr, head);
                check("out_predec_br", 32'(out_predec_br), 32'(opc == 6'd2 || opc == 6'd4));
            end
`ifdef FETCH_STATS_EN
            check("stat_fetched", stat_fetched, m_fetched);
            check("stat_dropped", stat_dropped, m_dropped);
`endif
        end
        tgt = redirect_pc & ~32'h3;
        if (reset) begin
            m_known = 1; m_active = 0; m_discard = 0; m_pc = '0;
            m_fetched = 0; m_dropped = 0;
            q_flush();
        end else if (m_known) begin
            if (!m_active) begin
                if (redirect_valid) begin
                    m_pc = tgt; q_flush();
                end else begin
                    if (pop) q_pop();
                    if (q_pc.size() < 2) begin m_active = 1; m_addr = m_pc; end
                end
            end else if (!m_discard) begin
                if (redirect_valid) begin
                    m_pc = tgt; q_flush();
                    if (iresp_ok) begin m_dropped++; m_active = 0; end
                    else m_discard = 1;
                end else begin
                    if (pop) q_pop();
                    if (iresp_ok) begin
                        q_pc.push_back(m_addr);
                        q_ins.push_back(iresp_data);
                        m_fetched++;
                        m_pc = m_addr + 32'd4;
                        if (q_pc.size() < 2) m_addr = m_addr + 32'd4;
                        else m_active = 0;
                    end
                end
            end else begin
                if (redirect_valid) begin m_pc = tgt; q_flush(); end
                else if (pop) q_pop();
                if (iresp_ok) begin m_dropped++; m_active = 0; m_discard = 0; end
            end
        end
    end

    // Advance to just after the next rising edge; memory echoes the address when requested.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (data_is_addr) iresp_data = m_addr;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1; iresp_ok = 0; redirect_valid = 0; out_ready = 0;
        cyc();
        reset = 0;
    endtask

    initial begin
        // Streaming: addresses 0,4,8,... with outputs one cycle behind.
        data_is_addr = 1;
        do_reset();
        out_ready = 1; iresp_ok = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            @(negedge clk);
            check("seq_addr", ireq_addr, 32'(4 * i));
            if (i > 0) begin
                check("seq_out_pc", out_pc, 32'(4 * (i - 1)));
                check("seq_out_instr", out_instr, 32'(4 * (i - 1)));
            end
        end

        // Stall: FIFO fills, requests stop, then drains 0,4 and resumes at 8.
        do_reset();
        out_ready = 0; iresp_ok = 1;
        repeat (9) cyc();
        @(negedge clk);
        check("stall_ireq_valid", 32'(ireq_valid), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head", out_pc, 32'h0);
        cyc(); out_ready = 1;
        @(negedge clk);
        check("drain0", out_pc, 32'h0);
        cyc();
        @(negedge clk);
        check("drain1", out_pc, 32'h4);
        check("resume_addr", ireq_addr, 32'h8);
        cyc();
        @(negedge clk);
        check("drain2", out_pc, 32'h8);

        // Redirect while waiting on 0x8, response arrives three cycles later.
        do_reset();
        out_ready = 1; iresp_ok = 0;
        cyc(); iresp_ok = 1;
        cyc();
        cyc(); iresp_ok = 0; redirect_valid = 1; redirect_pc = 32'h100;
        @(negedge clk);
        check("rd1_addr", ireq_addr, 32'h8);
        check("rd1_out_valid", 32'(out_valid), 32'd0);
        cyc(); redirect_valid = 0;
        @(negedge clk);
        check("flush_addr", ireq_addr, 32'h8);
        check("flush_valid", 32'(ireq_valid), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("flush_hold", ireq_addr, 32'h8);
        cyc(); iresp_ok = 1;
        @(negedge clk);
        check("flush_resp_addr", ireq_addr, 32'h8);
        cyc(); iresp_ok = 0;
        @(negedge clk);
        check("post_flush_idle", 32'(ireq_valid), 32'd0);
        check("dropped_not_out", 32'(out_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("redirect_addr", ireq_addr, 32'h100);
`ifdef FETCH_STATS_EN
        check("rd1_stat_dropped", stat_dropped, 32'd1);
        check("rd1_stat_fetched", stat_fetched, 32'd2);
`endif

        // Redirect to unaligned 0x203 in the same cycle as a response.
        do_reset();
        out_ready = 1; iresp_ok = 1;
        cyc();
        cyc(); redirect_valid = 1; redirect_pc = 32'h203;
        @(negedge clk);
        check("rd2_out_valid", 32'(out_valid), 32'd0);
        cyc(); redirect_valid = 0; iresp_ok = 0;
        @(negedge clk);
        check("rd2_fifo_empty", 32'(out_valid), 32'd0);
        check("rd2_idle", 32'(ireq_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("rd2_addr", ireq_addr, 32'h200);
`ifdef FETCH_STATS_EN
        check("rd2_stat_dropped", stat_dropped, 32'd1);
        check("rd2_stat_fetched", stat_fetched, 32'd1);
`endif

        // Branch predecode: J, BEQ, then an ADD word.
        data_is_addr = 0;
        do_reset();
        out_ready = 0; iresp_ok = 0;
        cyc(); iresp_ok = 1; iresp_data = 32'h0800_0010;
        cyc(); iresp_data = 32'h1000_0002;
        cyc(); iresp_ok = 0;
        @(negedge clk);
        check("pd_j_instr", out_instr, 32'h0800_0010);
        check("pd_j", 32'(out_predec_br), 32'd1);
        cyc(); out_ready = 1; iresp_ok = 1; iresp_data = 32'h0022_0820;
        @(negedge clk);
        check("pd_j_hold", 32'(out_predec_br), 32'd1);
        cyc();
        @(negedge clk);
        check("pd_beq_instr", out_instr, 32'h1000_0002);
        check("pd_beq", 32'(out_predec_br), 32'd1);
        cyc();
        @(negedge clk);
        check("pd_add_instr", out_instr, 32'h0022_0820);
        check("pd_add", 32'(out_predec_br), 32'd0);

        // Randomized traffic, including occasional mid-request resets.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset          = ($urandom_range(0, 299) == 0);
            iresp_ok       = ($urandom_range(0, 9) < 6);
            iresp_data     = $urandom;
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
        end
        cyc();
        reset = 0; redirect_valid = 0;
        @(negedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
